// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into a stream of press/auto-repeat events,
// serving one pending event per button round-robin over valid/ready.
module button_event_arbiter #(
    parameter int N_BTN         = 5,
    parameter int ID_W          = 3,
    parameter int CNT_W         = 26,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int REPEAT_EN     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_lvl,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_repeat,
    input  logic             evt_ready,
    output logic             overrun
);

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_PERIOD} state_t;

    localparam logic [CNT_W-1:0] DLY_END = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_END = CNT_W'(REPEAT_PERIOD - 1);

    logic [N_BTN-1:0] btn_q;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] prep_q, prep_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    state_t           state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             valid_q, valid_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rep_q, rep_d;
    logic             ovr_q, ovr_d;

    logic [N_BTN-1:0] press;
    logic             free, gnt, gnt_rep, fsm_load, rep_req;
    logic             hi_hit, lo_hit;
    logic [ID_W-1:0]  hi_id, lo_id, gnt_id;

    assign press = btn_lvl & ~btn_q;
    assign free  = ~valid_q | evt_ready;

    // Lowest pending index at or above rr wins; otherwise lowest below rr.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                if (ID_W'(i) >= rr_q) begin
                    hi_hit = 1'b1;
                    hi_id  = ID_W'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_id  = ID_W'(i);
                end
            end
        end
    end

    assign gnt_id   = hi_hit ? hi_id : lo_id;
    assign gnt      = free & (hi_hit | lo_hit);
    assign gnt_rep  = prep_q[gnt_id];
    assign fsm_load = gnt & ~gnt_rep & (REPEAT_EN != 0);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        owner_d = owner_q;
        rep_req = 1'b0;
        if (fsm_load) begin
            state_d = S_FIRST;
            tmr_d   = '0;
            owner_d = gnt_id;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tmr_d = '0;
                end
                S_FIRST: begin
                    if (!btn_lvl[owner_q]) begin
                        state_d = S_IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == DLY_END) begin
                        state_d = S_PERIOD;
                        tmr_d   = '0;
                        rep_req = 1'b1;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
                S_PERIOD: begin
                    if (!btn_lvl[owner_q]) begin
                        state_d = S_IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == PER_END) begin
                        tmr_d   = '0;
                        rep_req = 1'b1;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // Order matters: grant clears, repeat merges, press overrides the flag.
    always_comb begin
        pend_d = pend_q;
        prep_d = prep_q;
        ovr_d  = ovr_q;
        if (gnt) pend_d[gnt_id] = 1'b0;
        if ((press & pend_d) != '0) ovr_d = 1'b1;
        if (rep_req && !pend_d[owner_q]) begin
            pend_d[owner_q] = 1'b1;
            prep_d[owner_q] = 1'b1;
        end
        pend_d = pend_d | press;
        prep_d = prep_d & ~press;
    end

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        rep_d   = rep_q;
        rr_d    = rr_q;
        if (gnt) begin
            valid_d = 1'b1;
            id_d    = gnt_id;
            rep_d   = gnt_rep;
            rr_d    = (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + ID_W'(1);
        end else if (evt_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q   <= btn_lvl;
            pend_q  <= '0;
            prep_q  <= '0;
            rr_q    <= '0;
            state_q <= S_IDLE;
            owner_q <= '0;
            tmr_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            rep_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            btn_q   <= btn_lvl;
            pend_q  <= pend_d;
            prep_q  <= prep_d;
            rr_q    <= rr_d;
            state_q <= state_d;
            owner_q <= owner_d;
            tmr_q   <= tmr_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            rep_q   <= rep_d;
            ovr_q   <= ovr_d;
        end
    end

    assign evt_valid  = valid_q;
    assign evt_id     = id_q;
    assign evt_repeat = rep_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench: a deadline-based event model predicts each presented
// event; a monitor compares the DUT presentations against it.
module tb_button_event_arbiter;

    localparam int N  = 5;
    localparam int IW = 3;
    localparam int CW = 8;
    localparam int D  = 20;
    localparam int P  = 8;

    typedef struct {
        int e;
        int id;
        bit rep;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  btn = '0;
    logic          rdy = 1'b1;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic          evt_repeat;
    logic          overrun;

    int   checks = 0;
    int   fails  = 0;
    int   edge_no = 0;
    ev_t  expq[$];
    ev_t  seen[$];

    bit           pend[N];
    bit           prep[N];
    int           rr;
    bit           mv, movr, act;
    int           own, dl;
    logic [N-1:0] prev;

    button_event_arbiter #(
        .N_BTN(N), .ID_W(IW), .CNT_W(CW),
        .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .btn_lvl(btn),
        .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_repeat(evt_repeat), .evt_ready(rdy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", nm, a, x);
        end
    endtask

    // Reference: the repeat timer is an absolute deadline, not a counter.
    task automatic model_step();
        int  g;
        int  req;
        edge_no++;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                pend[i] = 0;
                prep[i] = 0;
            end
            rr = 0; mv = 0; movr = 0; act = 0; own = 0;
            prev = btn;
            return;
        end
        g = -1;
        if (!mv || rdy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr + k) % N;
                if (g < 0 && pend[j]) g = j;
            end
        end
        req = -1;
        if (g >= 0 && !prep[g]) begin
            act = 1; own = g; dl = edge_no + D;
        end else if (act) begin
            if (!btn[own]) act = 0;
            else if (edge_no == dl) begin
                req = own;
                dl  = edge_no + P;
            end
        end
        if (g >= 0) begin
            expq.push_back('{edge_no, g, prep[g]});
            pend[g] = 0;
            mv = 1;
            rr = (g + 1) % N;
        end else if (rdy) begin
            mv = 0;
        end
        for (int i = 0; i < N; i++)
            if (btn[i] && !prev[i] && pend[i]) movr = 1;
        if (req >= 0 && !pend[req]) begin
            pend[req] = 1;
            prep[req] = 1;
        end
        for (int i = 0; i < N; i++) begin
            if (btn[i] && !prev[i]) begin
                pend[i] = 1;
                prep[i] = 0;
            end
        end
        prev = btn;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        bit  pv;
        bit  nw;
        ev_t cur;
        pv  = 0;
        cur = '{0, 0, 0};
        forever begin
            @(posedge clk);
            #1;
            nw = evt_valid && (!pv || rdy);
            chk("valid", 32'(evt_valid), 32'(mv));
            chk("overrun", 32'(overrun), 32'(movr));
            if (nw) begin
                if (expq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_event id=%0d edge=%0d", evt_id, edge_no);
                end else begin
                    cur = expq.pop_front();
                end
                seen.push_back('{edge_no, int'(evt_id), evt_repeat});
            end
            while (expq.size() > 0) begin
                cur = expq.pop_front();
                checks++;
                fails++;
                $display("FAIL missing_event got=none want=id%0d", cur.id);
            end
            if (evt_valid && mv) begin
                chk("evt_id", 32'(evt_id), 32'(cur.id));
                chk("evt_repeat", 32'(evt_repeat), 32'(cur.rep));
            end
            pv = evt_valid;
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ord[5];
        int cnt;
        bit bad;
        step(3);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_id", 32'(evt_id), 0);
        chk("rst_rep", 32'(evt_repeat), 0);
        chk("rst_ovr", 32'(overrun), 0);
        rst = 0;
        step(3);

        // single press
        seen.delete();
        btn = 5'b00001;
        step(4);
        btn = '0;
        step(4);
        chk("single_cnt", seen.size(), 1);
        if (seen.size() > 0) begin
            chk("single_id", seen[0].id, 0);
            chk("single_rep", 32'(seen[0].rep), 0);
        end

        // simultaneous presses, round-robin order
        seen.delete();
        btn = 5'b11010;
        step(2);
        btn = '0;
        step(5);
        btn = 5'b01010;
        step(2);
        btn = '0;
        step(5);
        ord = '{1, 3, 4, 1, 3};
        chk("rr_cnt", seen.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < seen.size()) chk("rr_order", seen[k].id, ord[k]);

        // backpressure and overrun
        seen.delete();
        rdy = 0;
        btn = 5'b00010;
        step(2);
        btn = '0;
        step(1);
        btn = 5'b00100;
        step(2);
        btn = '0;
        step(2);
        btn = 5'b00100;
        step(2);
        btn = '0;
        step(14);
        chk("bp_ovr", 32'(overrun), 1);
        chk("bp_hold_id", 32'(evt_id), 1);
        rdy = 1;
        step(5);
        chk("bp_cnt", seen.size(), 2);
        if (seen.size() == 2) chk("bp_second", seen[1].id, 2);
        rst = 1;
        step(2);
        rst = 0;
        step(2);

        // auto-repeat timing
        seen.delete();
        btn = 5'b00001;
        step(50);
        btn = '0;
        step(20);
        chk("rpt_cnt", seen.size(), 5);
        if (seen.size() > 0) chk("rpt_press", 32'(seen[0].rep), 0);
        for (int k = 1; k < 5; k++) begin
            if (k < seen.size()) begin
                chk("rpt_flag", 32'(seen[k].rep), 1);
                chk("rpt_delta", seen[k].e - seen[0].e, 21 + 8 * (k - 1));
            end
        end

        // owner handover
        seen.delete();
        btn = 5'b00001;
        step(11);
        btn = 5'b00101;
        step(30);
        btn = '0;
        step(10);
        bad = 0;
        cnt = 0;
        foreach (seen[k]) begin
            if (seen[k].rep && seen[k].id == 0) bad = 1;
            if (seen[k].rep && seen[k].id == 2) cnt++;
        end
        chk("handover_no0", 32'(bad), 0);
        chk("handover_rep2", cnt, 2);

        // button held through reset
        btn = 5'b00100;
        rst = 1;
        step(3);
        rst = 0;
        seen.delete();
        step(10);
        chk("rst_held_cnt", seen.size(), 0);
        btn = '0;
        step(2);
        btn = 5'b00100;
        step(3);
        btn = '0;
        step(3);
        chk("repress_cnt", seen.size(), 1);
        if (seen.size() > 0) chk("repress_id", seen[0].id, 2);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 23) == 0) btn = btn ^ (5'(1) << i);
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 0;
        rdy = 1;
        btn = '0;
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
